// File: rtl/fifo_pkg.sv
// fifo_pkg
// Shared definitions for the single-clock FIFO:
//   clog2()          ceiling log2, used to size pointers and the fill count
//   FIFO_MODE_STD    read data is registered, one cycle after the pop
//   FIFO_MODE_FWFT   head word is presented combinationally while not empty
package fifo_pkg;

  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/fifo_mem_array.sv
// fifo_mem_array
// DEPTH x DATA_W storage for the FIFO. Storage is not reset.
// Ports:
//   clk     rising-edge clock for the write port
//   w_en    store w_data at w_addr on this edge
//   w_addr  write address
//   w_data  write word
//   r_addr  read address
//   r_data  combinational read of mem[r_addr]
module fifo_mem_array
  import fifo_pkg::*;
#(
  parameter int DATA_W = 560,
  parameter int DEPTH  = 16,
  parameter int AW     = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              w_en,
  input  logic [AW-1:0]     w_addr,
  input  logic [DATA_W-1:0] w_data,
  input  logic [AW-1:0]     r_addr,
  output logic [DATA_W-1:0] r_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (w_en) mem[w_addr] <= w_data;
  end

  assign r_data = mem[r_addr];

endmodule

// File: rtl/sync_fifo_param.sv
// sync_fifo_param
// Single-clock FIFO with standard or first-word-fall-through read, programmable
// almost-full / almost-empty thresholds, fill count and sticky error flags.
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   w_en, w_data    write request and word
//   w_full          FIFO holds DEPTH words
//   w_almost_full   count >= AF_THRESH
//   w_overflow      sticky: write attempted while full
//   r_en            read request (pop)
//   r_data          read word (registered in STD mode, head word in FWFT mode)
//   r_empty         FIFO holds no words
//   r_almost_empty  count <= AE_THRESH
//   r_underflow     sticky: read attempted while empty
//   count           current fill level, 0..DEPTH
//
// Handshake: w_en is the producer's valid and !w_full is the FIFO's ready; a
// word transfers on a rising edge only when both are high. r_en is the
// consumer's ready and !r_empty the FIFO's valid; a pop happens on a rising
// edge only when both are high. A request without the matching ready/valid is
// dropped and recorded in the sticky error flag.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_W    = 560,
  parameter int DEPTH     = 16,
  parameter int FWFT      = 0,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  w_en,
  input  logic [DATA_W-1:0]     w_data,
  output logic                  w_full,
  output logic                  w_almost_full,
  output logic                  w_overflow,
  input  logic                  r_en,
  output logic [DATA_W-1:0]     r_data,
  output logic                  r_empty,
  output logic                  r_almost_empty,
  output logic                  r_underflow,
  output logic [clog2(DEPTH):0] count
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

  // Elaboration-time legality checks.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sync_fifo_param: DEPTH must be a power of two >= 2");
  end
  if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
    $error("sync_fifo_param: AF_THRESH must be in 1..DEPTH");
  end
  if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
    $error("sync_fifo_param: AE_THRESH must be in 0..DEPTH-1");
  end
  if (FWFT != FIFO_MODE_STD && FWFT != FIFO_MODE_FWFT) begin : g_bad_mode
    $error("sync_fifo_param: FWFT must be 0 or 1");
  end

  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              wr_accept;
  logic              rd_accept;
  logic [DATA_W-1:0] mem_rd_data;

  // Acceptance uses the registered flags, so a write while full is dropped even
  // if a pop happens on the same edge (and likewise for a read while empty).
  assign wr_accept = w_en && !w_full;
  assign rd_accept = r_en && !r_empty;

  fifo_mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .clk    (clk),
    .w_en   (wr_accept),
    .w_addr (wr_ptr),
    .w_data (w_data),
    .r_addr (rd_ptr),
    .r_data (mem_rd_data)
  );

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      w_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (wr_accept) wr_ptr <= wr_ptr + 1'b1;
      if (rd_accept) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_accept, rd_accept})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (w_en && w_full)  w_overflow  <= 1'b1;
      if (r_en && r_empty) r_underflow <= 1'b1;
    end
  end

  // Flags are pure decodes of the registered count.
  assign w_full         = (count == DEPTH_C);
  assign r_empty        = (count == '0);
  assign w_almost_full  = (count >= AF_C);
  assign r_almost_empty = (count <= AE_C);

  if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
    // Head word is visible as soon as it is written; zero while empty.
    assign r_data = r_empty ? '0 : mem_rd_data;
  end else begin : g_std
    logic [DATA_W-1:0] r_data_q;
    // Capture the head word on a pop; hold otherwise, including on underflow.
    always_ff @(posedge clk or posedge rst) begin
      if (rst)            r_data_q <= '0;
      else if (rd_accept) r_data_q <= mem_rd_data;
    end
    assign r_data = r_data_q;
  end

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
- Single-clock, parametrised FIFO for wide datapath words (default 560 bits × 16 entries).
- Successor to the dual-clock FIFO, for blocks where producer and consumer share one clock.
- Adds selectable standard or first-word-fall-through read mode, programmable almost-full/almost-empty thresholds, fill count, and sticky overflow/underflow error flags.
- Sits between the matrix-data loader and downstream processing.

Parameters:
DATA_W, 560, word width in bits (>=1)
DEPTH, 16, number of entries; power of two, >=2
FWFT, 0, 0 = standard registered read, 1 = first-word-fall-through
AF_THRESH, DEPTH-2, w_almost_full asserts when count >= AF_THRESH (1..DEPTH)
AE_THRESH, 2, r_almost_empty asserts when count <= AE_THRESH (0..DEPTH-1)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
w_en  in  1  write request
w_data  in  DATA_W  write word
w_full  out  1  FIFO holds DEPTH words
w_almost_full  out  1  count >= AF_THRESH
w_overflow  out  1  sticky: write attempted while full
r_en  in  1  read request (pop)
r_data  out  DATA_W  read word
r_empty  out  1  FIFO holds 0 words
r_almost_empty  out  1  count <= AE_THRESH
r_underflow  out  1  sticky: read attempted while empty
count  out  clog2(DEPTH)+1  current fill level

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (rst).
- Reset:
  - Asserting rst clears immediately, without waiting for a clock edge: wr_ptr=0, rd_ptr=0, count=0, r_data=0, w_overflow=0, r_underflow=0.
  - Flags then read r_empty=1, w_full=0, w_almost_full=0, r_almost_empty=1.
  - Memory contents are not cleared.
  - Deassertion is synchronous to clk by the caller's guarantee.
- Accept rules, evaluated at each rising edge:
  - Write accepted = w_en && !w_full.
  - Read accepted = r_en && !r_empty.
  - A write while full is dropped even if r_en is high in the same cycle.
  - A read while empty is dropped even if w_en is high in the same cycle.
- Pointers and count:
  - Pointers are clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
  - Accepted write stores w_data at wr_ptr, then wr_ptr+1.
  - Accepted read: rd_ptr+1.
  - count: +1 on write only, -1 on read only, unchanged when both or neither are accepted.
- Flags are pure decodes of the registered count:
  - w_full = (count == DEPTH)
  - r_empty = (count == 0)
  - w_almost_full = (count >= AF_THRESH)
  - r_almost_empty = (count <= AE_THRESH)
  - All flags are valid in the cycle after the causing edge.
- Errors:
  - w_overflow sets on w_en && w_full; r_underflow sets on r_en && r_empty.
  - Both are cleared only by rst.
- Standard mode (FWFT=0):
  - r_data is registered. On an accepted read at edge N, r_data = mem[rd_ptr] after edge N (1-cycle latency).
  - Otherwise r_data holds its last value, including through underflow.
- FWFT mode (FWFT=1):
  - r_data = mem[rd_ptr] combinationally while !r_empty, and 0 while r_empty.
  - A write at edge N into an empty FIFO makes r_empty=0 with valid r_data after edge N.
  - r_en acknowledges (pops) the presented word.
- Ordering: strict first-in first-out, including across pointer wrap and simultaneous read/write at any fill level.
- Legality: elaboration-time error if DEPTH is not a power of two, or if either threshold is out of range.

Decomposition:
- Package fifo_pkg holds the clog2 function and the mode constants FIFO_MODE_STD=0 and FIFO_MODE_FWFT=1.
- One sub-module, fifo_mem_array: DEPTH×DATA_W register array with synchronous write and asynchronous read port.
- sync_fifo_param contains pointers, count, flags, error logic and the mode-dependent read register/mux.

Test Plan:
- Reset: hold rst=1 for 200 ns with w_en=r_en=1 -> count=0, r_empty=1, w_full=0, r_almost_empty=1, r_data=0, error flags 0. Assert rst mid-cycle -> outputs clear before the next edge.
- Fill (default params): write words 0..15 (word i = i replicated) -> w_almost_full rises after the 14th write, w_full after the 16th, count=16. A 17th w_en -> w_overflow=1, count stays 16, word 16 is never read back.
- Drain, standard mode: r_en for 16 cycles -> r_data = word i one cycle after the i-th accepted read, r_empty=1 after the 16th. A 17th r_en -> r_underflow=1, r_data stays word 15.
- Wrap and concurrency: preload 8 words, then w_en=r_en=1 for 40 cycles with incrementing data -> count stays 8, pointers wrap twice, read sequence strictly equals write sequence.
- FWFT=1: write one word 0xA5…A5 into an empty FIFO -> after that edge r_empty=0 and r_data=0xA5…A5 with no r_en. A single r_en -> r_empty=1, r_data=0.
- Reset mid-operation: at count=5 assert rst -> count=0 immediately. Then write 0x3C…3C and read (standard mode) -> r_data=0x3C…3C, no stale data returned.
